// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point FFT sequencer.
package fft8_pkg;

    localparam int N           = 8;
    localparam int LOG2N       = 3;
    localparam int WORD_SZ_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        UNLOAD
    } state_t;

    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] v);
        return {v[0], v[1], v[2]};
    endfunction

endpackage

// File: rtl/fft8_addr_gen.sv
// Butterfly operand addresses and twiddle index for stage s, butterfly k.
// Purely combinational; no handshake.
module fft8_addr_gen
    import fft8_pkg::*;
(
    input  logic [1:0]       s_i,
    input  logic [1:0]       k_i,
    output logic [LOG2N-1:0] addr_a_o,
    output logic [LOG2N-1:0] addr_b_o,
    output logic [1:0]       tw_idx_o
);

    logic [LOG2N-1:0] k3;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] tw_full;

    always_comb begin
        k3       = {1'b0, k_i};
        span     = 3'b001 << s_i;
        mask     = span - 3'b001;
        // Group index lands above the span bits, position within group below.
        addr_a_o = ((k3 >> s_i) << (s_i + 2'd1)) | (k3 & mask);
        addr_b_o = addr_a_o + span;
        tw_full  = (k3 & mask) << (2'd2 - s_i);
        tw_idx_o = tw_full[1:0];
    end

endmodule

// File: rtl/fft8_sched.sv
// Sequencer driving one shared radix-2 butterfly through an in-place 8-point FFT.
// Load 8 (stallable), 12 fixed compute cycles, unload 8 under downstream backpressure.
module fft8_sched
    import fft8_pkg::*;
#(
    parameter int WORD_SZ = WORD_SZ_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [WORD_SZ-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [WORD_SZ-1:0] o_bf_A,
    output logic [WORD_SZ-1:0] o_bf_B,
    output logic [1:0]         o_tw_idx,
    output logic               o_bf_en,
    input  logic [WORD_SZ-1:0] i_bf_A,
    input  logic [WORD_SZ-1:0] i_bf_B,
    output logic [WORD_SZ-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_done
);

    state_t           state_q;
    logic [WORD_SZ-1:0] mem_q [N];
    logic [LOG2N-1:0] n_q;
    logic [LOG2N-1:0] m_q;
    logic [1:0]       s_q;
    logic [1:0]       k_q;

    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [1:0]       tw_idx;
    logic             in_hs;
    logic             out_hs;

    fft8_addr_gen u_addr_gen (
        .s_i      (s_q),
        .k_i      (k_q),
        .addr_a_o (addr_a),
        .addr_b_o (addr_b),
        .tw_idx_o (tw_idx)
    );

    assign o_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign o_bf_en  = (state_q == COMPUTE);
    assign o_valid  = (state_q == UNLOAD);
    assign o_busy   = (state_q != IDLE);

    assign in_hs    = i_valid & o_ready;
    assign out_hs   = o_valid & i_ready;
    assign o_done   = out_hs && (m_q == 3'd7);

    assign o_bf_A   = mem_q[addr_a];
    assign o_bf_B   = mem_q[addr_b];
    assign o_tw_idx = o_bf_en ? tw_idx : 2'd0;
    assign o_data   = mem_q[m_q];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            m_q     <= '0;
            s_q     <= '0;
            k_q     <= '0;
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (in_hs) begin
                        mem_q[bitrev3(n_q)] <= i_data;
                        n_q <= n_q + 3'd1;
                        if (n_q == 3'd7) begin
                            state_q <= COMPUTE;
                            s_q     <= '0;
                            k_q     <= '0;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                COMPUTE: begin
                    // Write-back lands before the next read, so stages chain without a gap.
                    mem_q[addr_a] <= i_bf_A;
                    mem_q[addr_b] <= i_bf_B;
                    if (k_q == 2'd3) begin
                        k_q <= '0;
                        if (s_q == 2'd2) begin
                            s_q     <= '0;
                            m_q     <= '0;
                            state_q <= UNLOAD;
                        end else begin
                            s_q <= s_q + 2'd1;
                        end
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                UNLOAD: begin
                    if (out_hs) begin
                        m_q <= m_q + 3'd1;
                        if (m_q == 3'd7) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fft8_sched.md
Name: fft8_sched

Overview:
- Sequencer for the 8-point FFT demo. One shared radix-2 butterfly (the DFT_2 datapath plus an external twiddle multiplier) is reused for all 12 butterflies.
- Accepts 8 complex samples over a valid/ready stream and stores them bit-reversed in an internal 8-entry buffer.
- Issues 3 stages × 4 butterflies, one per cycle, writing results back in place.
- Streams the 8 results out in natural order.

Parameters:
- WORD_SZ, 16, complex word width: real part in the upper WORD_SZ/2 bits, imaginary part in the lower WORD_SZ/2 bits.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_data  input  WORD_SZ  input sample.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  block accepts a sample this cycle.
- o_bf_A  output  WORD_SZ  butterfly operand A, equal to buf[addr_a].
- o_bf_B  output  WORD_SZ  butterfly operand B, equal to buf[addr_b].
- o_tw_idx  output  2  twiddle index k, meaning W8^k applied to B.
- o_bf_en  output  1  operands and o_tw_idx are valid this cycle.
- i_bf_A  input  WORD_SZ  butterfly result A, combinational from o_bf_*.
- i_bf_B  input  WORD_SZ  butterfly result B.
- o_data  output  WORD_SZ  output sample.
- o_valid  output  1  o_data is valid.
- i_ready  input  1  downstream accepts o_data.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse on the last accepted output.

Behaviour:
- Reset (synchronous, i_rst high at an edge):
  - State goes to IDLE and all counters clear.
  - o_ready=1, o_valid=0, o_bf_en=0, o_done=0, o_busy=0, o_tw_idx=0.
  - o_bf_A, o_bf_B and o_data read 0 because the buffer is cleared.
  - Reset mid-LOAD, mid-COMPUTE or mid-UNLOAD abandons the frame. No partial output is emitted.
- States: IDLE → LOAD → COMPUTE → UNLOAD → IDLE.
- IDLE:
  - o_ready=1.
  - A handshake (i_valid & o_ready) writes i_data to buf[bitrev(0)=0] and sets n=1.
  - Next state is LOAD.
- LOAD:
  - o_ready=1.
  - Each handshake writes buf[bitrev(n)] and increments n. The bitrev order is 0,4,2,6,1,5,3,7.
  - Cycles with i_valid=0 are stalls: nothing is written and n holds.
  - On the handshake with n=7, the next state is COMPUTE, with s=0 and k=0.
- COMPUTE:
  - o_ready=0 and o_bf_en=1 for exactly 12 consecutive cycles. There are no stalls.
  - Addressing for stage s (0..2) and butterfly k (0..3):
    - span = 1<<s.
    - addr_a = ((k>>s)<<(s+1)) | (k & (span-1)).
    - addr_b = addr_a + span.
    - o_tw_idx = (k & (span-1)) << (2-s).
  - Required issue order:
    - s0: (0,1) (2,3) (4,5) (6,7), all tw 0.
    - s1: (0,2)t0 (1,3)t2 (4,6)t0 (5,7)t2.
    - s2: (0,4)t0 (1,5)t1 (2,6)t2 (3,7)t3.
  - At each edge, buf[addr_a] takes i_bf_A and buf[addr_b] takes i_bf_B.
  - Stage s+1 sees the results of stage s because the write completes before the next read. Latency is 1 cycle per butterfly.
  - After (s=2, k=3) the next state is UNLOAD with m=0.
- UNLOAD:
  - o_valid=1 and o_data=buf[m].
  - A handshake (o_valid & i_ready) increments m. If i_ready=0, o_data and m hold.
  - On the handshake with m=7, o_done pulses in that cycle and the next state is IDLE, where o_ready=1 again.
- No overlap between frames: input is refused from COMPUTE until the return to IDLE.
- Arithmetic and width:
  - The controller performs no arithmetic on data. Words are stored verbatim.
  - Any overflow or wrap (mod 2^(WORD_SZ/2) per component) belongs to the external datapath.
- i_bf_A/i_bf_B are ignored when o_bf_en=0. o_bf_A/o_bf_B are don't-care when o_bf_en=0.

Decomposition:
- Package fft8_pkg:
  - Constants: N=8, LOG2N=3, default WORD_SZ=16.
  - State enum: IDLE, LOAD, COMPUTE, UNLOAD.
  - 3-bit bitrev function.
- Sub-module fft8_addr_gen:
  - Combinational.
  - Input: s, k.
  - Outputs: addr_a, addr_b, tw_idx.
  - Instantiated once by fft8_sched; also reused by the bench scoreboard.

Test Plan:
1. Address/twiddle sequence: load 8 samples; during COMPUTE log (addr_a, addr_b, o_tw_idx) → exact 12-entry order as listed in COMPUTE; o_bf_en high for exactly 12 cycles.
2. Constant input, bench butterfly = DFT_2 sum/difference with twiddle 1: all x[n]=(1,0) → outputs X[0]=(8,0), X[1..7]=(0,0), in order; o_done on 8th output.
3. Impulse x[0]=(1,0), others 0, same butterfly model → all 8 outputs (1,0); full W8 bench model matches a reference DFT for x=(2,3),(4,1),0,... .
4. Stalls and backpressure: i_valid toggles 1/0 during LOAD and i_ready low for 3 cycles at m=4 → no lost or duplicated samples; o_data holds buf[4] through the stall.
5. Reset mid-COMPUTE at s=1, k=2 → next cycle IDLE, o_ready=1, o_valid=0, o_busy=0; a fresh frame then completes correctly.
6. Back-to-back frames: start a new frame the cycle after o_done → o_ready seen 1 in IDLE; second frame's results are independent of the first.
